// File: rtl/lpc_target_responder.sv
// LPC target-side response engine: drives SYNC, read data and turnaround nibbles on LAD
// after the host's TAR phase, with wait-state insertion, timeout error SYNC and LFRAME# abort.
module lpc_target_responder #(
  parameter int DATA_BYTES     = 4,
  parameter int SHORT_WAIT_MAX = 8,
  parameter int MAX_WAIT       = 64
) (
  input  logic                    LpcClock,
  input  logic                    PciReset,
  input  logic                    LpcFrame_n,
  input  logic                    Start,
  input  logic                    Claim,
  input  logic                    Opcode,
  input  logic [1:0]              NumBytes,
  input  logic [8*DATA_BYTES-1:0] DataRd,
  input  logic                    DataValid,
  inout  wire  [3:0]              LpcBus,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Timeout
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] SHORT_W = WW'(SHORT_WAIT_MAX);
  localparam logic [WW-1:0] MAX_W   = WW'(MAX_WAIT);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_DATA_LO = 3'd2;
  localparam logic [2:0] ST_DATA_HI = 3'd3;
  localparam logic [2:0] ST_TAR     = 3'd4;

  localparam logic [3:0] SYNC_READY = 4'h0;
  localparam logic [3:0] SYNC_SHORT = 4'h5;
  localparam logic [3:0] SYNC_LONG  = 4'h6;
  localparam logic [3:0] SYNC_ERROR = 4'hA;
  localparam logic [3:0] TAR_NIB    = 4'hF;

  logic [2:0]              state_q, state_d;
  logic                    oe_q, oe_d;
  logic [3:0]              nibble_q, nibble_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    timeout_q, timeout_d;
  logic [WW-1:0]           wait_q, wait_d;
  logic [1:0]              idx_q, idx_d;
  logic [1:0]              nbytes_q, nbytes_d;
  logic                    write_q, write_d;
  logic                    tar_q, tar_d;
  logic [8*DATA_BYTES-1:0] data_q, data_d;

  logic [1:0] nb_clamped;
  logic [7:0] byte_arr [DATA_BYTES];
  logic [7:0] cur_byte;
  logic       do_sync;
  logic       is_write;

  always_comb begin
    if (int'(NumBytes) > DATA_BYTES - 1) nb_clamped = 2'(DATA_BYTES - 1);
    else                                 nb_clamped = NumBytes;
  end

  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_bytes
    assign byte_arr[gi] = data_q[gi*8 +: 8];
  end

  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (idx_q == 2'(i)) cur_byte = byte_arr[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    oe_d      = oe_q;
    nibble_d  = nibble_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    wait_d    = wait_q;
    idx_d     = idx_q;
    nbytes_d  = nbytes_q;
    write_d   = write_q;
    tar_d     = tar_q;
    data_d    = data_q;
    do_sync   = 1'b0;
    is_write  = write_q;

    case (state_q)
      ST_IDLE: begin
        if (Start && Claim) begin
          oe_d     = 1'b1;
          busy_d   = 1'b1;
          write_d  = Opcode;
          nbytes_d = nb_clamped;
          idx_d    = 2'd0;
          tar_d    = 1'b0;
          is_write = Opcode;
          do_sync  = 1'b1;
        end
      end
      ST_SYNC: do_sync = 1'b1;
      ST_DATA_LO: begin
        nibble_d = cur_byte[3:0];
        state_d  = ST_DATA_HI;
      end
      ST_DATA_HI: begin
        nibble_d = cur_byte[7:4];
        if (idx_q < nbytes_q) begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_DATA_LO;
        end else begin
          state_d = ST_TAR;
        end
      end
      ST_TAR: begin
        // First TAR edge drives 0xF; the second releases the bus.
        if (!tar_q) begin
          nibble_d = TAR_NIB;
          tar_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tar_d   = 1'b0;
          wait_d  = '0;
          idx_d   = 2'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Shared by the IDLE entry edge (wait_q is zero there) and every SYNC edge.
    if (do_sync) begin
      if (DataValid) begin
        nibble_d = SYNC_READY;
        if (!is_write) data_d = DataRd;
        state_d  = is_write ? ST_TAR : ST_DATA_LO;
      end else if (wait_q == MAX_W) begin
        nibble_d  = SYNC_ERROR;
        timeout_d = 1'b1;
        if (!is_write) data_d = '1;
        state_d   = is_write ? ST_TAR : ST_DATA_LO;
      end else begin
        nibble_d = (wait_q < SHORT_W) ? SYNC_SHORT : SYNC_LONG;
        wait_d   = wait_q + 1'b1;
        state_d  = ST_SYNC;
      end
    end

    if (state_q != ST_IDLE && !LpcFrame_n) begin
      state_d   = ST_IDLE;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      timeout_d = 1'b0;
      wait_d    = '0;
      idx_d     = 2'd0;
      tar_d     = 1'b0;
    end
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      state_q   <= ST_IDLE;
      oe_q      <= 1'b0;
      nibble_q  <= 4'h0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      wait_q    <= '0;
      idx_q     <= 2'd0;
      nbytes_q  <= 2'd0;
      write_q   <= 1'b0;
      tar_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      oe_q      <= oe_d;
      nibble_q  <= nibble_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      wait_q    <= wait_d;
      idx_q     <= idx_d;
      nbytes_q  <= nbytes_d;
      write_q   <= write_d;
      tar_q     <= tar_d;
      data_q    <= data_d;
    end
  end

  assign LpcBus  = oe_q ? nibble_q : 4'hz;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Timeout = timeout_q;

endmodule

// File: tb/tb_lpc_target_responder.sv
// Bench for lpc_target_responder: two configurations (4 and 2 data bytes), each observed through
// a pulled-up and a pulled-down LAD net so Hi-Z is distinguishable from a driven 0xF.
module tb_lpc_target_responder;

  localparam int SHORT = 8;
  localparam int MAXW  = 64;

  typedef struct packed {
    logic [3:0] nib;
    logic       to;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        frame_n;
  logic        start;
  logic        claim;
  logic        opcode;
  logic [1:0]  nbytes;
  logic [31:0] data_rd;
  logic        dv;

  exp_t exp_q [2][$];
  int   exp_done [2];
  int   total = 0;
  int   bad   = 0;
  int   ntxn  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gcfg
    localparam int DB = (g == 0) ? 4 : 2;
    wire [3:0] lad_up;
    wire [3:0] lad_dn;
    pullup   (lad_up);
    pulldown (lad_dn);
    logic busy_u, done_u, to_u, busy_n, done_n, to_n;
    logic [4:0] obs;
    logic [4:0] last_obs;
    logic       driven;
    exp_t       e;

    lpc_target_responder #(.DATA_BYTES(DB), .SHORT_WAIT_MAX(SHORT), .MAX_WAIT(MAXW)) u_up (
      .LpcClock(clk), .PciReset(rst_n), .LpcFrame_n(frame_n), .Start(start), .Claim(claim),
      .Opcode(opcode), .NumBytes(nbytes), .DataRd(data_rd[8*DB-1:0]), .DataValid(dv),
      .LpcBus(lad_up), .Busy(busy_u), .Done(done_u), .Timeout(to_u));

    lpc_target_responder #(.DATA_BYTES(DB), .SHORT_WAIT_MAX(SHORT), .MAX_WAIT(MAXW)) u_dn (
      .LpcClock(clk), .PciReset(rst_n), .LpcFrame_n(frame_n), .Start(start), .Claim(claim),
      .Opcode(opcode), .NumBytes(nbytes), .DataRd(data_rd[8*DB-1:0]), .DataValid(dv),
      .LpcBus(lad_dn), .Busy(busy_n), .Done(done_n), .Timeout(to_n));

    // 0..15 driven value, 16 Hi-Z, 17 inconsistent
    always_comb begin
      if (lad_up == lad_dn)                       obs = {1'b0, lad_up};
      else if (lad_up == 4'hF && lad_dn == 4'h0)  obs = 5'h10;
      else                                        obs = 5'h11;
    end

    initial begin
      last_obs = 5'h10;
      forever begin
        @(negedge clk);
        driven = (obs < 5'h10);
        if (obs == 5'h11) begin
          total++; bad++;
          $display("FAIL lad_conflict cfg%0d up=%h dn=%h", g, lad_up, lad_dn);
        end
        total++;
        if (busy_u !== driven || busy_n !== driven) begin
          bad++;
          $display("FAIL busy cfg%0d got=%0b/%0b want=%0b", g, busy_u, busy_n, driven);
        end
        if (driven) begin
          total++;
          if (exp_q[g].size() == 0) begin
            bad++;
            $display("FAIL lad_extra cfg%0d got=%h want=hi-z", g, obs[3:0]);
          end else begin
            e = exp_q[g].pop_front();
            if (obs[3:0] !== e.nib || to_u !== e.to || to_n !== e.to) begin
              bad++;
              $display("FAIL lad_nibble cfg%0d got=%h/to=%0b want=%h/to=%0b",
                       g, obs[3:0], to_u, e.nib, e.to);
            end
          end
        end else begin
          total++;
          if (to_u || to_n) begin
            bad++;
            $display("FAIL timeout_idle cfg%0d got=%0b/%0b want=0", g, to_u, to_n);
          end
        end
        if (done_u || done_n) begin
          total++;
          if (exp_done[g] == 0 || driven || last_obs != 5'h0F || !(done_u && done_n)) begin
            bad++;
            $display("FAIL done cfg%0d got=%0b/%0b pending=%0d prev=%h want=pulse after TAR",
                     g, done_u, done_n, exp_done[g], last_obs);
          end else begin
            exp_done[g]--;
          end
        end
        last_obs = obs;
      end
    end
  end

  function automatic exp_t mk(input logic [3:0] nib, input logic to);
    exp_t r;
    r.nib = nib;
    r.to  = to;
    return r;
  endfunction

  // Reference: expected LAD nibble list from the cycle rules, truncated at an abort edge.
  task automatic model(input int g, input int db, input bit rd, input int nb, input int w,
                       input logic [31:0] data, input int abort_k, output int dlen);
    exp_t l[$];
    int n;
    bit tmo;
    int waits;
    logic [7:0] b;
    n     = (nb >= db) ? db : nb + 1;
    tmo   = (w > MAXW);
    waits = tmo ? MAXW : w;
    for (int i = 0; i < waits; i++) l.push_back(mk((i < SHORT) ? 4'h5 : 4'h6, 1'b0));
    l.push_back(mk(tmo ? 4'hA : 4'h0, tmo));
    if (rd) begin
      for (int k = 0; k < n; k++) begin
        b = tmo ? 8'hFF : data[8*k +: 8];
        l.push_back(mk(b[3:0], 1'b0));
        l.push_back(mk(b[7:4], 1'b0));
      end
    end
    l.push_back(mk(4'hF, 1'b0));
    dlen = l.size();
    for (int i = 0; i < dlen; i++) begin
      if (abort_k < 1 || i < abort_k) exp_q[g].push_back(l[i]);
    end
    if (abort_k < 1 || abort_k > dlen) exp_done[g]++;
  endtask

  task automatic check_leftover(input string tag);
    for (int g = 0; g < 2; g++) begin
      total++;
      if (exp_q[g].size() != 0 || exp_done[g] != 0) begin
        bad++;
        $display("FAIL leftover_%s cfg%0d got=%0d nibbles/%0d dones pending want=0/0",
                 tag, g, exp_q[g].size(), exp_done[g]);
      end
      exp_q[g].delete();
      exp_done[g] = 0;
    end
  endtask

  task automatic check_reset(input string tag);
    total++;
    if (!(gcfg[0].lad_up == 4'hF && gcfg[0].lad_dn == 4'h0 && !gcfg[0].busy_u &&
          !gcfg[0].done_u && !gcfg[0].to_u && gcfg[1].lad_up == 4'hF &&
          gcfg[1].lad_dn == 4'h0 && !gcfg[1].busy_u && !gcfg[1].done_u && !gcfg[1].to_u)) begin
      bad++;
      $display("FAIL reset_%s got lad=%h/%h busy=%0b done=%0b to=%0b want hi-z and zeros",
               tag, gcfg[0].lad_up, gcfg[0].lad_dn, gcfg[0].busy_u, gcfg[0].done_u, gcfg[0].to_u);
    end
  endtask

  task automatic run_txn(input bit cl, input bit rd, input int nb, input int w,
                         input logic [31:0] data, input int abort_k, input bit restart);
    int d0, d1, dm;
    d0 = 0; d1 = 0;
    if (cl) begin
      model(0, 4, rd, nb, w, data, abort_k, d0);
      model(1, 2, rd, nb, w, data, abort_k, d1);
      dm = (d0 > d1) ? d0 : d1;
    end else begin
      dm = 3;
    end
    for (int e = 0; e <= dm + 1; e++) begin
      start   = (e == 0) || (restart && e == 2);
      claim   = cl;
      opcode  = !rd;
      nbytes  = nb[1:0];
      dv      = (e >= w);
      data_rd = (e == w) ? data : $urandom;
      frame_n = !(e == abort_k);
      @(posedge clk); #1;
    end
    start = 1'b0; dv = 1'b0; frame_n = 1'b1; claim = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_leftover("txn");
    ntxn++;
    $display("txn %0d claim=%0b rd=%0b nb=%0d wait=%0d data=%h abort=%0d restart=%0b",
             ntxn, cl, rd, nb, w, data, abort_k, restart);
  endtask

  initial begin
    int d;
    bit rd, cl, rs;
    int nb, w, ab, sel;
    rst_n = 1'b0; frame_n = 1'b1; start = 1'b0; claim = 1'b0; opcode = 1'b0;
    nbytes = 2'd0; data_rd = '0; dv = 1'b0;
    exp_done[0] = 0; exp_done[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("init");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_txn(1, 1, 0, 0, 32'h000000A5, -1, 0);
    run_txn(1, 1, 3, 3, 32'h44332211, -1, 0);
    run_txn(1, 1, 1, 1000, 32'h12345678, -1, 0);
    run_txn(1, 0, 0, 2, 32'h0, -1, 0);
    run_txn(0, 1, 0, 0, 32'hDEADBEEF, -1, 0);
    run_txn(1, 1, 3, 0, 32'hCAFEF00D, 5, 0);
    run_txn(1, 1, 3, 64, 32'h8899AABB, -1, 0);
    run_txn(1, 0, 2, 65, 32'h0, -1, 0);
    run_txn(1, 1, 2, 1, 32'h0BADF00D, -1, 1);

    // Asynchronous reset in the middle of SYNC
    model(0, 4, 1, 0, 100, 32'h0, 4, d);
    model(1, 2, 1, 0, 100, 32'h0, 4, d);
    for (int e = 0; e < 4; e++) begin
      start = (e == 0); claim = 1'b1; opcode = 1'b0; nbytes = 2'd0; dv = 1'b0; frame_n = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0; claim = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset("midsync");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_leftover("reset");

    for (int t = 0; t < 30; t++) begin
      rd  = 1'($urandom_range(0, 1));
      cl  = ($urandom_range(0, 7) != 0);
      nb  = int'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      w = int'($urandom_range(0, 10));
      else if (sel < 8) w = int'($urandom_range(60, 68));
      else              w = 1000;
      ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 20)) : -1;
      rs  = ($urandom_range(0, 3) == 0) && (ab < 1 || ab >= 2);
      run_txn(cl, rd, nb, w, $urandom, ab, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=time limit reached want=bench completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
